// File: rtl/rpn_calc_core.sv
// Keypad-driven RPN calculator core: hex entry register, DEPTH-entry operand stack, 8-op ALU.
// Optional multiplier for op 7 is enabled by defining RPN_CALC_MUL_EN.
module rpn_calc_core #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [4:0]                   key_code,
  output logic [W-1:0]                 display,
  output logic [1:0]                   state,
  output logic [$clog2(DEPTH+1)-1:0]   stack_cnt,
  output logic [1:0]                   err_code,
  output logic                         busy,
  output logic                         flag_c,
  output logic                         flag_z,
  output logic                         key_drop
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(W);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
`ifdef RPN_CALC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_EXEC  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OVF   = 2'd1;
  localparam logic [1:0] ERR_UNF   = 2'd2;
  localparam logic [1:0] ERR_ILLOP = 2'd3;

  state_e          state_q, state_d;
  logic [W-1:0]    stack_q [DEPTH];
  logic [W-1:0]    stack_d [DEPTH];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    entry_q, entry_d;
  logic            dirty_q, dirty_d;
  logic [1:0]      err_q, err_d;
  logic            flag_c_q, flag_c_d;
  logic            flag_z_q, flag_z_d;
  logic            key_drop_q, key_drop_d;
  logic [W-1:0]    display_q, display_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            exec_dirty_q, exec_dirty_d;

  logic [AW-1:0]   tos_idx, nos_idx, push_idx, disp_idx;
  logic [W:0]      alu_wide;
  logic [W-1:0]    alu_res;
  logic            alu_c;

  assign tos_idx  = AW'(cnt_q - 1'b1);
  assign nos_idx  = AW'(cnt_q - CNT_TWO);
  assign push_idx = AW'(cnt_q);

  // Operands were latched on entry to EXEC, so the ALU sees stable inputs for the whole cycle.
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = flag_c_q;
    case (op_q)
      3'd0: begin
        alu_wide = {1'b0, a_q} + {1'b0, b_q};
        alu_res  = alu_wide[W-1:0];
        alu_c    = alu_wide[W];
      end
      3'd1: begin
        alu_wide = {1'b0, a_q} - {1'b0, b_q};
        alu_res  = alu_wide[W-1:0];
        alu_c    = alu_wide[W];
      end
      3'd2: alu_res = a_q & b_q;
      3'd3: alu_res = a_q | b_q;
      3'd4: alu_res = a_q ^ b_q;
      3'd5: alu_res = a_q << b_q[SW-1:0];
      3'd6: alu_res = a_q >> b_q[SW-1:0];
`ifdef RPN_CALC_MUL_EN
      3'd7: alu_res = a_q * b_q;
`else
      3'd7: alu_res = '0;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    stack_d      = stack_q;
    cnt_d        = cnt_q;
    entry_d      = entry_q;
    dirty_d      = dirty_q;
    err_d        = err_q;
    flag_c_d     = flag_c_q;
    flag_z_d     = flag_z_q;
    key_drop_d   = 1'b0;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    exec_dirty_d = exec_dirty_q;

    case (state_q)
      ST_EXEC: begin
        key_drop_d = key_valid;
        flag_z_d   = (alu_res == '0);
        if (op_q == 3'd0 || op_q == 3'd1) flag_c_d = alu_c;
        if (exec_dirty_q) begin
          stack_d[tos_idx] = alu_res;
        end else begin
          stack_d[nos_idx] = alu_res;
          cnt_d            = cnt_q - 1'b1;
        end
        entry_d = '0;
        dirty_d = 1'b0;
        state_d = ST_ENTRY;
      end

      ST_ERROR: begin
        if (key_valid && key_code == 5'h11) begin
          entry_d = '0;
          dirty_d = 1'b0;
          err_d   = ERR_NONE;
          state_d = ST_ENTRY;
        end
      end

      default: begin
        if (key_valid) begin
          if (!key_code[4]) begin
            entry_d = dirty_q ? {entry_q[W-5:0], key_code[3:0]}
                              : {{(W-4){1'b0}}, key_code[3:0]};
            dirty_d = 1'b1;
          end else if (key_code[3]) begin
            // Errors are decided here so an illegal or short-operand op never enters EXEC.
            op_d = key_code[2:0];
            if (!MUL_EN && key_code[2:0] == 3'd7) begin
              err_d   = ERR_ILLOP;
              state_d = ST_ERROR;
            end else if (dirty_q) begin
              if (cnt_q == '0) begin
                err_d   = ERR_UNF;
                state_d = ST_ERROR;
              end else begin
                a_d          = stack_q[tos_idx];
                b_d          = entry_q;
                exec_dirty_d = 1'b1;
                state_d      = ST_EXEC;
              end
            end else begin
              if (cnt_q < CNT_TWO) begin
                err_d   = ERR_UNF;
                state_d = ST_ERROR;
              end else begin
                a_d          = stack_q[nos_idx];
                b_d          = stack_q[tos_idx];
                exec_dirty_d = 1'b0;
                state_d      = ST_EXEC;
              end
            end
          end else begin
            case (key_code[2:0])
              3'd0: begin
                if (cnt_q == CNT_FULL) begin
                  err_d   = ERR_OVF;
                  state_d = ST_ERROR;
                end else begin
                  stack_d[push_idx] = dirty_q ? entry_q : '0;
                  cnt_d             = cnt_q + 1'b1;
                  entry_d           = '0;
                  dirty_d           = 1'b0;
                end
              end
              3'd1: begin
                entry_d = '0;
                dirty_d = 1'b0;
                err_d   = ERR_NONE;
              end
              3'd2: begin
                if (dirty_q) begin
                  entry_d = '0;
                  dirty_d = 1'b0;
                end else if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
                end else begin
                  err_d   = ERR_UNF;
                  state_d = ST_ERROR;
                end
              end
              3'd3: begin
                if (cnt_q < CNT_TWO) begin
                  err_d   = ERR_UNF;
                  state_d = ST_ERROR;
                end else begin
                  stack_d[tos_idx] = stack_q[nos_idx];
                  stack_d[nos_idx] = stack_q[tos_idx];
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Display is registered from next-state values so it changes on the same edge as the state it shows.
  assign disp_idx = AW'(cnt_d - 1'b1);
  always_comb begin
    display_d = '0;
    if (dirty_d)            display_d = entry_d;
    else if (cnt_d != '0)   display_d = stack_d[disp_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ENTRY;
      stack_q      <= '{default: '0};
      cnt_q        <= '0;
      entry_q      <= '0;
      dirty_q      <= 1'b0;
      err_q        <= ERR_NONE;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      key_drop_q   <= 1'b0;
      display_q    <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      exec_dirty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stack_q      <= stack_d;
      cnt_q        <= cnt_d;
      entry_q      <= entry_d;
      dirty_q      <= dirty_d;
      err_q        <= err_d;
      flag_c_q     <= flag_c_d;
      flag_z_q     <= flag_z_d;
      key_drop_q   <= key_drop_d;
      display_q    <= display_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      exec_dirty_q <= exec_dirty_d;
    end
  end

  assign display   = display_q;
  assign state     = state_q;
  assign stack_cnt = cnt_q;
  assign err_code  = err_q;
  assign busy      = (state_q == ST_EXEC);
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign key_drop  = key_drop_q;

endmodule

// File: tb/tb_rpn_calc_core.sv
// Directed bench for rpn_calc_core (W=16, DEPTH=4); op 7 expectations follow RPN_CALC_MUL_EN.
module tb_rpn_calc_core;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_valid = 1'b0;
  logic [4:0]    key_code = '0;
  logic [W-1:0]  display;
  logic [1:0]    state;
  logic [2:0]    stack_cnt;
  logic [1:0]    err_code;
  logic          busy;
  logic          flag_c;
  logic          flag_z;
  logic          key_drop;

  int checks   = 0;
  int failures = 0;

  rpn_calc_core #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .display   (display),
    .state     (state),
    .stack_cnt (stack_cnt),
    .err_code  (err_code),
    .busy      (busy),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .key_drop  (key_drop)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] K_ENTER = 5'h10, K_CLR = 5'h11, K_DROP = 5'h12, K_SWAP = 5'h13;
  localparam logic [4:0] K_ADD = 5'h18, K_SUB = 5'h19, K_AND = 5'h1A, K_OR = 5'h1B;
  localparam logic [4:0] K_XOR = 5'h1C, K_SHL = 5'h1D, K_SHR = 5'h1E, K_MUL = 5'h1F;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an op key, confirm exactly one busy cycle, and leave the bench just after completion.
  task automatic do_op(input logic [4:0] k, input string tag);
    press(k);
    chk({tag, "_busy1"}, busy, 1);
    chk({tag, "_state_exec"}, state, 1);
    tick();
    chk({tag, "_busy0"}, busy, 0);
    chk({tag, "_state_entry"}, state, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_display", display, 0);
    chk("rst_state", state, 0);
    chk("rst_cnt", stack_cnt, 0);
    chk("rst_err", err_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {flag_c, flag_z, key_drop}, 0);
    @(negedge clk);
    rst = 1'b0;

    press(5'h1); press(5'h2); press(5'hA); press(5'hF);
    chk("entry_12af", display, 16'h12AF);
    chk("entry_cnt0", stack_cnt, 0);
    press(K_ENTER);
    chk("enter_cnt1", stack_cnt, 1);
    chk("enter_disp", display, 16'h12AF);

    press(5'h5);
    chk("digit_zext", display, 16'h0005);
    press(K_ENTER);
    press(5'h3);
    do_op(K_SUB, "sub_dirty");
    chk("sub_dirty_disp", display, 16'h0002);
    chk("sub_dirty_cnt", stack_cnt, 2);
    chk("sub_dirty_c", flag_c, 0);
    chk("sub_dirty_z", flag_z, 0);

    do_op(K_SUB, "sub_clean");
    chk("sub_clean_disp", display, 16'h12AD);
    chk("sub_clean_cnt", stack_cnt, 1);

    press(K_DROP);
    chk("drop_cnt0", stack_cnt, 0);
    chk("drop_disp0", display, 0);

    press(5'hF); press(5'hF); press(5'hF); press(5'hF);
    press(K_ENTER);
    press(5'h1);
    press(K_ENTER);
    chk("pre_add_cnt", stack_cnt, 2);
    do_op(K_ADD, "add_wrap");
    chk("add_wrap_disp", display, 0);
    chk("add_wrap_c", flag_c, 1);
    chk("add_wrap_z", flag_z, 1);
    chk("add_wrap_cnt", stack_cnt, 1);

    press(5'h1);
    do_op(K_SUB, "sub_borrow");
    chk("sub_borrow_disp", display, 16'hFFFF);
    chk("sub_borrow_c", flag_c, 1);
    chk("sub_borrow_z", flag_z, 0);

    press(5'hF); press(5'h0); press(5'hF); press(5'h0);
    do_op(K_XOR, "xor");
    chk("xor_disp", display, 16'h0F0F);
    chk("xor_keeps_c", flag_c, 1);

    press(5'h4);
    do_op(K_SHL, "shl");
    chk("shl_disp", display, 16'hF0F0);
    press(5'h8);
    do_op(K_SHR, "shr");
    chk("shr_disp", display, 16'h00F0);
    press(5'h3); press(5'hC);
    do_op(K_AND, "and");
    chk("and_disp", display, 16'h0030);
    press(5'h5);
    do_op(K_OR, "or");
    chk("or_disp", display, 16'h0035);
    chk("or_cnt", stack_cnt, 1);

    press(5'h1); press(5'h2); press(5'h3); press(5'h4); press(5'h5);
    chk("digit_shiftout", display, 16'h2345);
    press(K_CLR);
    chk("clr_shows_tos", display, 16'h0035);
    chk("clr_keeps_cnt", stack_cnt, 1);

    press(K_SWAP);
    chk("swap_unf_err", err_code, 2);
    chk("swap_unf_state", state, 2);
    press(5'h7);
    chk("err_ignores_digit", display, 16'h0035);
    press(K_CLR);
    chk("err_clr_state", state, 0);
    chk("err_clr_err", err_code, 0);

    press(5'h9);
    press(K_ENTER);
    press(K_SWAP);
    chk("swap_disp", display, 16'h0035);
    press(K_DROP);
    chk("swap_drop_disp", display, 16'h0009);
    chk("swap_drop_cnt", stack_cnt, 1);
    press(K_DROP);
    press(5'h6);
    press(K_DROP);
    chk("drop_dirty_disp", display, 0);
    chk("drop_dirty_state", state, 0);
    press(K_DROP);
    chk("drop_empty_err", err_code, 2);
    press(K_CLR);

    press(K_ADD);
    chk("add_empty_err", err_code, 2);
    chk("add_empty_state", state, 2);
    chk("add_empty_busy", busy, 0);
    press(K_CLR);

    press(5'h1); press(K_ENTER);
    press(5'h2); press(K_ENTER);
    press(5'h3); press(K_ENTER);
    press(5'h4); press(K_ENTER);
    chk("full_cnt", stack_cnt, 4);
    press(K_ENTER);
    chk("ovf_err", err_code, 1);
    chk("ovf_state", state, 2);
    chk("ovf_cnt", stack_cnt, 4);
    chk("ovf_disp", display, 16'h0004);
    press(5'h9);
    chk("ovf_ignores_digit", display, 16'h0004);
    press(K_CLR);
    chk("ovf_clr_state", state, 0);
    chk("ovf_clr_cnt", stack_cnt, 4);

    // Op key, then a digit held through the EXEC cycle: it must be dropped, not entered.
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = K_ADD;
    @(posedge clk);
    #1;
    chk("drop_test_busy", busy, 1);
    key_code = 5'h5;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    chk("key_drop_pulse", key_drop, 1);
    chk("key_drop_disp", display, 16'h0007);
    chk("key_drop_cnt", stack_cnt, 3);
    tick();
    chk("key_drop_clear", key_drop, 0);
    chk("key_drop_still_clean", display, 16'h0007);

    press(5'h1); press(5'h0); press(K_ENTER);
    press(5'h1); press(5'h0);
    press(K_MUL);
`ifdef RPN_CALC_MUL_EN
    chk("mul_busy", busy, 1);
    tick();
    chk("mul_disp", display, 16'h0100);
    chk("mul_cnt", stack_cnt, 4);
    chk("mul_state", state, 0);
`else
    chk("mul_illop_err", err_code, 3);
    chk("mul_illop_state", state, 2);
    chk("mul_illop_cnt", stack_cnt, 4);
    chk("mul_illop_disp", display, 16'h0010);
    press(K_CLR);
`endif

    press(K_ADD);
    chk("rst_exec_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_exec_state", state, 0);
    chk("rst_exec_cnt", stack_cnt, 0);
    chk("rst_exec_disp", display, 0);
    chk("rst_exec_flags", {flag_c, flag_z, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_exec_after", display, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
